// File: rtl/riscy_pkg.sv
// Shared types and decode helpers for the RISCY accumulator CPU control path.
package riscy_pkg;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/riscy_phase_counter.sv
// Three-bit wrapping phase counter; freezes while hold is high, cleared by reset.
module riscy_phase_counter
  import riscy_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       hold,
  output logic [2:0] phase
);

  logic [2:0] phase_q;
  logic [2:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!hold) begin
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q <= INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/riscy_sequencer.sv
// RISCY control sequencer: eight-phase fetch/decode/execute with a sticky halt flag
// and a combinational decode of phase, opcode and zero into datapath strobes.
module riscy_sequencer
  import riscy_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt
);

  logic [2:0] phase;
  logic       halted_q;
  logic       halted_d;
  phase_e     cur_phase;
  opcode_e    op;
  logic       aluop;

  riscy_phase_counter u_phase_counter (
    .CLK   (CLK),
    .RST   (RST),
    .hold  (halted_q),
    .phase (phase)
  );

  assign cur_phase = phase_e'(phase);
  assign op        = opcode_e'(opcode);
  assign aluop     = is_aluop(opcode);

  // The HLT edge still advances the phase; the counter freezes from the next cycle.
  always_comb begin
    halted_d = halted_q;
    if (!halted_q && (cur_phase == OP_ADDR) && (op == HLT)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    unique case (cur_phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (op == SKZ) && zero;
        ld_pc  = (op == JMP);
        data_e = (op == STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (op == JMP);
        data_e = (op == STO);
        wr     = (op == STO);
      end
    endcase
    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
    end
  end

  assign halt = halted_q;

endmodule

// File: tb/tb_riscy_sequencer.sv
// Scoreboard bench for riscy_sequencer: a driver advances a reference model and queues
// expected strobes; a monitor compares on each falling clock edge or reset assertion.
module tb_riscy_sequencer;

  logic       CLK;
  logic       RST;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  riscy_sequencer dut (
    .CLK    (CLK),
    .RST    (RST),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_exp;
  logic [8:0]  mon_got;

  // Reference model state: phase number and halted flag.
  int m_phase;
  bit m_halted;

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} from the phase rules.
  function automatic logic [8:0] model_out(input int ph, input logic [2:0] op,
                                           input logic z, input bit h);
    bit alu;
    bit s, r, li, ip, lp, la, w, de;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    s  = (ph <= 3);
    r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    li = (ph == 2) || (ph == 3);
    ip = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    lp = (ph >= 6) && (op == 3'd7);
    la = (ph == 7) && alu;
    w  = (ph == 7) && (op == 3'd6);
    de = (ph >= 6) && (op == 3'd6);
    if (h) return 9'b0_0000_0001;
    return {s, r, li, ip, lp, la, w, de, 1'b0};
  endfunction

  task automatic push_exp();
    exp_q.push_back(model_out(m_phase, opcode, zero, m_halted));
  endtask

  // One clock: update the model across the edge, then apply new inputs for this cycle.
  task automatic step(input logic [2:0] op, input logic z, input logic rst_v);
    @(posedge CLK);
    #1;
    if (RST && !m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      m_phase = (m_phase + 1) % 8;
    end
    RST = rst_v;
    if (!rst_v) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end
    opcode = (m_phase >= 4) ? op : 3'($urandom_range(0, 7));
    zero   = z;
    push_exp();
  endtask

  // Eight clocks starting from phase 0: phases 1..7 then back to 0.
  task automatic run_instr(input logic [2:0] op, input logic z);
    repeat (8) step(op, z, 1'b1);
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2;
    RST      = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    push_exp();
  endtask

  always @(negedge CLK or negedge RST) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL strobes t=%0t sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt got=%b exp=%b",
                 $time, mon_got, mon_exp);
      end
    end
  end

  initial begin
    RST      = 1'b0;
    opcode   = 3'd0;
    zero     = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;

    // Reset state, then release.
    step(3'd0, 1'b0, 1'b0);
    step(3'd0, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b1);

    // Directed instructions.
    run_instr(3'd2, 1'b0);  // ADD
    run_instr(3'd6, 1'b0);  // STO
    run_instr(3'd1, 1'b1);  // SKZ taken
    run_instr(3'd1, 1'b0);  // SKZ not taken
    run_instr(3'd7, 1'b1);  // JMP
    run_instr(3'd5, 1'b1);  // LDA

    // Random program, no HLT.
    repeat (30) run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));

    // HLT, then a frozen machine for 20 clocks, then a reset pulse.
    run_instr(3'd0, 1'b0);
    repeat (20) step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    async_reset();
    step(3'd0, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b1);
    run_instr(3'd3, 1'b0);  // AND after recovery

    // LDA interrupted by reset in phase 5.
    repeat (5) step(3'd5, 1'b0, 1'b1);
    async_reset();
    step(3'd5, 1'b0, 1'b0);
    step(3'd5, 1'b0, 1'b1);
    run_instr(3'd5, 1'b0);
    run_instr(3'd4, 1'b1);  // XOR

    @(negedge CLK);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscy_sequencer.md
# riscy_sequencer

Eight-phase control sequencer for the RISCY 8-bit accumulator CPU. Steps a phase counter through fetch, decode and execute for each instruction. Decodes the current 3-bit opcode and the accumulator zero flag into the strobes that drive the datapath:

- address mux
- memory read and write
- instruction register
- program counter
- accumulator
- data bus driver

Sits between the instruction register and the RISCY datapath. A HLT opcode freezes the machine until reset.

## Interface
Parameters:
- none. Widths are fixed by the RISCY ISA: 3-bit opcode, 8 phases.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-low; clears the phase to INST_ADDR and clears halt
- opcode  input  3  opcode field from the instruction register; sampled combinationally
- zero  input  1  accumulator-is-zero flag from the ALU
- sel  output  1  address mux select: 1 = PC, 0 = IR operand address
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc  output  1  load program counter from IR operand (jump)
- ld_ac  output  1  load accumulator from ALU result
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto the data bus
- halt  output  1  machine halted (sticky)

## Operation
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
  - ALUOP = ADD, AND, XOR or LDA
- A phase register advances 0→7 and wraps to 0, once per clock. One instruction takes exactly 8 cycles.
- Outputs are a combinational decode of the registered phase, opcode and zero. There are no registered outputs except halt.
- Per-phase outputs (any output not listed is 0):
  - 0 INST_ADDR: sel=1
  - 1 INST_FETCH: sel=1, rd=1
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1
  - 3 IDLE: sel=1, rd=1, ld_ir=1
  - 4 OP_ADDR: inc_pc=1. If opcode==HLT, the halted flag sets on this edge.
  - 5 OP_FETCH: rd=ALUOP
  - 6 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO)
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); data_e=(opcode==STO); wr=(opcode==STO)
- Halted state:
  - Halted flag set → phase holds at its current value (OP_ADDR+1 = OP_FETCH).
  - All strobes except halt are forced to 0.
  - halt output = halted flag.
  - Only RST clears it.
- SKZ with zero=0 produces no extra PC increment. Execution then continues to the next instruction.

## Timing
- Reset values:
  - phase = 0
  - halted = 0
  - sel = 1 (INST_ADDR decode)
  - all other outputs 0
- RST deassertion: first rising edge moves the phase to 1.
- RST assertion mid-instruction (any phase): immediate asynchronous return to phase 0. Outputs reflect the INST_ADDR decode with no clock edge required.
- opcode must be stable from phase 4 through phase 7. It is a don't-care in phases 0–3.
- ld_ir is held for 2 cycles (phases 2–3). The IR must tolerate a double load.
- wr is asserted only in phase 7, one cycle after data_e rises. data_e covers phases 6–7 so bus data is stable before and during wr.
- Halt:
  - A HLT in phase 4 asserts halt on the following edge.
  - inc_pc is asserted during that phase-4 cycle, so PC points past the HLT.
- Phase counter wrap 7→0 has no gap cycle.

## Structure
- riscy_pkg holds:
  - typedef enum logic [2:0] for the phases: INST_ADDR … STORE
  - typedef enum logic [2:0] for the opcodes: HLT … JMP
  - function is_aluop(opcode)
- One sub-module, riscy_phase_counter: 3-bit wrapping counter with a hold input (halted), asynchronous active-low clear.
- The top level contains the halted flag and the combinational output decode, written as a unique case on phase.

## Test plan
- Reset then ADD, zero=0, 8 clocks:
  - sel=1 in phases 0–3
  - rd=1 in phases 1–3 and 5–7
  - ld_ir=1 in phases 2–3
  - inc_pc=1 in phase 4 only
  - ld_ac=1 in phase 7 only
  - wr=0 and ld_pc=0 throughout
- STO: data_e=1 in phases 6–7; wr=1 in phase 7 only; rd=0 and ld_ac=0 in phases 5–7.
- SKZ: with zero=1, inc_pc=1 in phases 4 and 6. With zero=0, inc_pc=1 in phase 4 only.
- JMP: ld_pc=1 in phases 6–7; rd=0 in phases 5–7.
- HLT:
  - halt=1 after the phase-4 edge
  - the next 20 clocks show phase frozen, all strobes 0, halt=1
  - pulsing RST low gives phase=0, halt=0, sel=1
- RST low asynchronously mid-phase 5 of an LDA: outputs go to the reset values before the next edge. After release, the sequence restarts at phase 0 and the LDA strobe timing is correct for a new instruction.
